// File: rtl/aemb_wb_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone classic arbiter for aeMB.
// Round-robin grant under contention, with a per-transfer wait-cycle timeout.
module aemb_wb_arbiter #(
  parameter int AW  = 16,
  parameter int TMO = 15
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          iwb_stb_i,
  input  logic [AW-1:0] iwb_adr_i,
  output logic [31:0]   iwb_dat_o,
  output logic          iwb_ack_o,
  input  logic          dwb_stb_i,
  input  logic          dwb_we_i,
  input  logic [3:0]    dwb_sel_i,
  input  logic [AW-1:0] dwb_adr_i,
  input  logic [31:0]   dwb_dat_i,
  output logic [31:0]   dwb_dat_o,
  output logic          dwb_ack_o,
  output logic          mem_stb_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_sel_o,
  output logic [AW-1:0] mem_adr_o,
  output logic [31:0]   mem_dat_o,
  input  logic [31:0]   mem_dat_i,
  input  logic          mem_ack_i,
  output logic          tmo_o
);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  localparam logic       LAST_I  = 1'b0;
  localparam logic       LAST_D  = 1'b1;
  localparam logic [7:0] TMO_CNT = 8'(TMO);

  state_t     state_reg;
  logic       last_reg;
  logic [7:0] cnt_reg;

  logic granted;
  logic tmo_hit;
  logic done;

  // A slave ack in the timeout cycle wins: the abort only fires with no ack.
  assign granted = (state_reg != IDLE);
  assign tmo_hit = granted & ~mem_ack_i & (cnt_reg == TMO_CNT);
  assign done    = granted & (mem_ack_i | tmo_hit);

  assign iwb_ack_o = (state_reg == IGNT) & done;
  assign dwb_ack_o = (state_reg == DGNT) & done;
  assign iwb_dat_o = tmo_hit ? 32'h0 : mem_dat_i;
  assign dwb_dat_o = tmo_hit ? 32'h0 : mem_dat_i;
  assign tmo_o     = tmo_hit;

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_reg <= IDLE;
      last_reg  <= LAST_I;
      cnt_reg   <= 8'h0;
      mem_stb_o <= 1'b0;
      mem_we_o  <= 1'b0;
      mem_sel_o <= 4'h0;
      mem_adr_o <= '0;
      mem_dat_o <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Under contention the master that was not served last wins.
          if (dwb_stb_i && (!iwb_stb_i || last_reg == LAST_I)) begin
            state_reg <= DGNT;
            last_reg  <= LAST_D;
            cnt_reg   <= 8'h0;
            mem_stb_o <= 1'b1;
            mem_we_o  <= dwb_we_i;
            mem_sel_o <= dwb_sel_i;
            mem_adr_o <= dwb_adr_i;
            mem_dat_o <= dwb_dat_i;
          end else if (iwb_stb_i) begin
            state_reg <= IGNT;
            last_reg  <= LAST_I;
            cnt_reg   <= 8'h0;
            mem_stb_o <= 1'b1;
            mem_we_o  <= 1'b0;
            mem_sel_o <= 4'hF;
            mem_adr_o <= iwb_adr_i;
            mem_dat_o <= 32'h0;
          end
        end
        IGNT, DGNT: begin
          if (done) begin
            state_reg <= IDLE;
            mem_stb_o <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 8'h1;
          end
        end
        default: begin
          state_reg <= IDLE;
          mem_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aemb_wb_arbiter.sv
// Directed bench for aemb_wb_arbiter: vector table of single transfers plus
// hand-written contention and reset-mid-transfer sequences.
module tb_aemb_wb_arbiter;

  localparam int AW  = 16;
  localparam int TMO = 15;

  logic          sys_clk_i = 1'b0;
  logic          sys_rst_i;
  logic          iwb_stb_i;
  logic [AW-1:0] iwb_adr_i;
  logic [31:0]   iwb_dat_o;
  logic          iwb_ack_o;
  logic          dwb_stb_i;
  logic          dwb_we_i;
  logic [3:0]    dwb_sel_i;
  logic [AW-1:0] dwb_adr_i;
  logic [31:0]   dwb_dat_i;
  logic [31:0]   dwb_dat_o;
  logic          dwb_ack_o;
  logic          mem_stb_o;
  logic          mem_we_o;
  logic [3:0]    mem_sel_o;
  logic [AW-1:0] mem_adr_o;
  logic [31:0]   mem_dat_o;
  logic [31:0]   mem_dat_i;
  logic          mem_ack_i;
  logic          tmo_o;

  aemb_wb_arbiter #(.AW(AW), .TMO(TMO)) dut (
    .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
    .iwb_stb_i(iwb_stb_i), .iwb_adr_i(iwb_adr_i), .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o),
    .dwb_stb_i(dwb_stb_i), .dwb_we_i(dwb_we_i), .dwb_sel_i(dwb_sel_i), .dwb_adr_i(dwb_adr_i),
    .dwb_dat_i(dwb_dat_i), .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o),
    .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o), .mem_adr_o(mem_adr_o),
    .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i), .tmo_o(tmo_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  sel;
    logic [15:0] adr;
    logic [31:0] wdat;
    int          wait_cyc;   // granted cycle index in which the slave acks; >15 means never
    logic [31:0] rdat;
    logic        exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdat;
    logic [31:0] exp_ack_dat;
    logic        exp_tmo;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs [NVEC];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic        done;
    logic        own_ack;
    logic        other_ack;
    logic [31:0] own_dat;
    @(posedge sys_clk_i); #1;
    if (v.is_d) begin
      dwb_stb_i = 1'b1; dwb_we_i = v.we; dwb_sel_i = v.sel; dwb_adr_i = v.adr; dwb_dat_i = v.wdat;
      iwb_adr_i = 16'hFFFF;
    end else begin
      iwb_stb_i = 1'b1; iwb_adr_i = v.adr;
      dwb_we_i = 1'b1; dwb_sel_i = 4'h5; dwb_adr_i = 16'hEEEE; dwb_dat_i = 32'hFFFFFFFF;
    end
    @(posedge sys_clk_i); #1;
    check($sformatf("v%0d mem_stb", idx), mem_stb_o, 1'b1);
    check($sformatf("v%0d mem_adr", idx), mem_adr_o, v.adr);
    check($sformatf("v%0d mem_we", idx), mem_we_o, v.exp_we);
    check($sformatf("v%0d mem_sel", idx), mem_sel_o, v.exp_sel);
    check($sformatf("v%0d mem_dat", idx), mem_dat_o, v.exp_wdat);
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (k > 0) begin
        @(posedge sys_clk_i); #1;
      end
      if (k == v.wait_cyc) begin
        mem_ack_i = 1'b1; mem_dat_i = v.rdat;
        done = 1'b1;
      end else begin
        mem_ack_i = 1'b0; mem_dat_i = 32'h5555AAAA;
        if (k == TMO) done = 1'b1;
      end
      #1;
      own_ack   = v.is_d ? dwb_ack_o : iwb_ack_o;
      other_ack = v.is_d ? iwb_ack_o : dwb_ack_o;
      own_dat   = v.is_d ? dwb_dat_o : iwb_dat_o;
      if (done) begin
        check($sformatf("v%0d ack", idx), own_ack, 1'b1);
        check($sformatf("v%0d ack_dat", idx), own_dat, v.exp_ack_dat);
        check($sformatf("v%0d tmo", idx), tmo_o, v.exp_tmo);
        check($sformatf("v%0d other_ack", idx), other_ack, 1'b0);
      end else if (own_ack !== 1'b0 || tmo_o !== 1'b0) begin
        check($sformatf("v%0d early_ack_c%0d", idx, k), {own_ack, tmo_o}, 2'b00);
      end
    end
    if (!done) check($sformatf("v%0d completed", idx), 1'b0, 1'b1);
    @(posedge sys_clk_i); #1;
    mem_ack_i = 1'b0; iwb_stb_i = 1'b0; dwb_stb_i = 1'b0;
    #1;
    check($sformatf("v%0d idle_stb", idx), mem_stb_o, 1'b0);
    check($sformatf("v%0d tmo_one_cycle", idx), tmo_o, 1'b0);
    $display("vector %0d: %s adr=%h wait=%0d done", idx, v.is_d ? "dwb" : "iwb", v.adr, v.wait_cyc);
  endtask

  // Waits (bounded) for a grant and reports whether the data master got it.
  task automatic wait_grant(input string name, output logic seen, output logic is_d);
    seen = 1'b0;
    is_d = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge sys_clk_i); #1;
      if (mem_stb_o) seen = 1'b1;
    end
    check({name, " seen"}, seen, 1'b1);
    if (seen) is_d = (mem_adr_o == 16'h2000);
  endtask

  initial begin
    logic seen;
    logic got_d;

    vecs[0] = '{1'b0, 1'b0, 4'h0, 16'h0040, 32'h0, 1, 32'hB0000010, 1'b0, 4'hF, 32'h0, 32'hB0000010, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 16'h8004, 32'h12345678, 0, 32'h0BADF00D, 1'b1, 4'h3, 32'h12345678, 32'h0BADF00D, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 16'h0100, 32'h0, 3, 32'hDEADBEEF, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'hF, 16'h0200, 32'h0, 99, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 4'h0, 16'h0044, 32'h0, 0, 32'h11112222, 1'b0, 4'hF, 32'h0, 32'h11112222, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 4'h0, 16'h0048, 32'h0, 15, 32'hCAFEF00D, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 4'hC, 16'h7FFC, 32'hA5A5A5A5, 14, 32'h00000001, 1'b1, 4'hC, 32'hA5A5A5A5, 32'h00000001, 1'b0};

    sys_rst_i = 1'b1;
    iwb_stb_i = 1'b0; iwb_adr_i = '0;
    dwb_stb_i = 1'b0; dwb_we_i = 1'b0; dwb_sel_i = 4'h0; dwb_adr_i = '0; dwb_dat_i = 32'h0;
    mem_dat_i = 32'h0; mem_ack_i = 1'b0;
    repeat (3) @(posedge sys_clk_i);
    #1;
    check("rst mem_stb", mem_stb_o, 1'b0);
    check("rst mem_we", mem_we_o, 1'b0);
    check("rst mem_sel", mem_sel_o, 4'h0);
    check("rst mem_adr", mem_adr_o, 16'h0);
    check("rst mem_dat", mem_dat_o, 32'h0);
    check("rst acks_tmo", {iwb_ack_o, dwb_ack_o, tmo_o}, 3'b000);
    $display("reset state checked");
    sys_rst_i = 1'b0;

    // Contention straight out of reset, both strobes held: D, I, D, I.
    @(posedge sys_clk_i); #1;
    iwb_stb_i = 1'b1; iwb_adr_i = 16'h1000;
    dwb_stb_i = 1'b1; dwb_adr_i = 16'h2000; dwb_we_i = 1'b0; dwb_sel_i = 4'hF;
    for (int g = 0; g < 4; g++) begin
      wait_grant($sformatf("cont%0d", g), seen, got_d);
      if (seen) begin
        check($sformatf("cont%0d is_d", g), got_d, (g % 2 == 0));
        mem_ack_i = 1'b1; mem_dat_i = 32'h100 + 32'(g);
        #1;
        check($sformatf("cont%0d acks", g), {dwb_ack_o, iwb_ack_o}, (g % 2 == 0) ? 2'b10 : 2'b01);
        @(posedge sys_clk_i); #1;
        mem_ack_i = 1'b0;
        check($sformatf("cont%0d idle_gap", g), mem_stb_o, 1'b0);
        $display("contention grant %0d: %s", g, got_d ? "dwb" : "iwb");
      end
    end
    iwb_stb_i = 1'b0; dwb_stb_i = 1'b0;
    @(posedge sys_clk_i); #1;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Reset while an instruction fetch is outstanding.
    @(posedge sys_clk_i); #1;
    iwb_stb_i = 1'b1; iwb_adr_i = 16'h0080;
    @(posedge sys_clk_i); #1;
    check("rstmid granted", mem_stb_o, 1'b1);
    mem_ack_i = 1'b1; mem_dat_i = 32'h77777777;
    #1;
    sys_rst_i = 1'b1;
    #1;
    check("rstmid mem_stb", mem_stb_o, 1'b0);
    check("rstmid iwb_ack", iwb_ack_o, 1'b0);
    $display("reset mid-transfer checked");
    @(posedge sys_clk_i); #1;
    mem_ack_i = 1'b0;
    sys_rst_i = 1'b0;
    iwb_adr_i = 16'h1000;
    dwb_stb_i = 1'b1; dwb_adr_i = 16'h2000;
    wait_grant("postrst", seen, got_d);
    if (seen) check("postrst is_d", got_d, 1'b1);
    mem_ack_i = 1'b1;
    @(posedge sys_clk_i); #1;
    mem_ack_i = 1'b0; iwb_stb_i = 1'b0; dwb_stb_i = 1'b0;
    $display("post-reset contention granted %s", got_d ? "dwb" : "iwb");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
